uart_fifo_bridge: RTL and testbench
===================================

# uart_fifo_bridge

Byte-buffering stage between the CPU peripheral bus and the simple UART's data register. It holds a TX FIFO that drains into the UART transmitter under its wait handshake. It holds an RX FIFO that empties the UART's single-byte receive buffer as soon as a byte lands. Firmware can burst up to 2^DEPTH_LOG2 bytes each way without per-byte polling.

## Interface
- DEPTH_LOG2, 4, log2 of entries per FIFO; legal range 1..7 (2..128 entries)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- bus_dat_we  in  1  CPU write to data register (push TX)
- bus_dat_re  in  1  CPU read of data register (pop RX)
- bus_dat_di  in  32  write data; only [7:0] used
- bus_dat_do  out  32  {23'b0, rx_valid, rx_head[7:0]}; all zero when RX FIFO empty
- bus_dat_wait  out  1  bus_dat_we && tx_full; CPU holds the write until low
- bus_stat_do  out  32  [0] rx nonempty, [1] rx full, [2] tx empty, [3] tx full, [15:8] rx level, [23:16] tx level, rest 0
- uart_dat_we  out  1  write strobe to UART data register
- uart_dat_di  out  32  {24'b0, tx_head[7:0]}
- uart_dat_wait  in  1  UART busy; combinational function of uart_dat_we
- uart_dat_re  out  1  read/clear strobe to UART receive buffer
- uart_dat_do  in  32  UART receive word; [8] valid, [7:0] data
- irq  out  1  present only with UART_FIFO_IRQ_EN (see Configuration)

## Operation
- Two circular FIFOs, each with DEPTH_LOG2-bit rd/wr pointers (natural wrap) and a (DEPTH_LOG2+1)-bit level; full = level==2^DEPTH_LOG2, empty = level==0.
- TX push: bus_dat_we && !tx_full. When full, no push; bus_dat_wait stays high until a drain frees a slot. Full status is registered, so a drain in the same cycle does not release the wait.
- TX drain: uart_dat_we = !tx_empty. Pop on uart_dat_we && !uart_dat_wait. No combinational path from uart_dat_wait back to uart_dat_we.
- RX capture: uart_dat_re = uart_dat_do[8] && !rx_full. On the same cycle, push uart_dat_do[7:0]. The UART clears valid at that edge, so each byte is pushed exactly once.
- RX full: no read. The byte stays in the UART. A further byte arriving there overwrites it undetected; this loss is accepted and not reported.
- RX pop: bus_dat_re && !rx_empty. bus_dat_re while empty returns 0 and changes nothing.
- Simultaneous push+pop on one FIFO: level unchanged, both pointers advance. On an empty RX FIFO a concurrent read returns 0 and the pushed byte is retained.
- Reset: pointers, levels and irq cleared. Resulting outputs: uart_dat_we=0, uart_dat_re=0, bus_dat_do=0, bus_dat_wait=0, bus_stat_do=0x00000004. FIFO contents are discarded. A byte already accepted by the UART finishes transmitting.

## Timing
- CPU write at edge N: uart_dat_we is high in cycle N+1. Minimum 1-cycle latency.
- Back-to-back UART acceptance: one byte per cycle when uart_dat_wait is low.
- UART valid seen in cycle N: the byte is pushed at edge N and visible on bus_dat_do / bus_stat_do in cycle N+1.
- bus_dat_do, bus_stat_do, uart_dat_di: combinational from registered FIFO state; zero wait on reads.
- uart_dat_re is combinational from uart_dat_do[8] and registered rx_full; it is gated low while reset is high.

## Configuration
- UART_FIFO_IRQ_EN defined: adds output irq, registered, reset 0. irq is set the cycle after rx level becomes nonzero, or the cycle after the TX FIFO transitions nonempty->empty. irq is cleared the cycle after any bus_dat_re or bus_dat_we.
- Not defined: irq port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then idle: bus_stat_do=0x00000004, uart_dat_we=0, bus_dat_do=0.
- Write 0x41,0x42,0x43 back-to-back with uart_dat_wait held high 20 cycles: uart_dat_we high from cycle after first write, bytes 0x41,0x42,0x43 accepted in order after release, tx level 3→0.
- DEPTH_LOG2=2: five writes with UART stalled: bus_dat_wait asserts on 5th, tx full bit=1; releasing one UART accept lets the 5th write complete next cycle.
- UART presents valid 0x155 (byte 0x55): uart_dat_re pulses one cycle, bus_dat_do=0x00000155 next cycle; read pops, then bus_dat_do=0.
- Fill RX to full (4 bytes, DEPTH_LOG2=2), 5th byte held in UART with uart_dat_re=0; one CPU read, 5th byte captured next cycle; readback order preserved across pointer wrap.
- Reset asserted with 3 bytes in each FIFO: levels 0, uart_dat_we=0 next cycle; with UART_FIFO_IRQ_EN, irq=0.

Source files
------------

// File: rtl/uart_fifo_bridge_if.sv
// Bus-side and UART-side data-register signals of the UART FIFO bridge.
// The bridge uses the slave modport; the CPU/UART environment uses master.
interface uart_fifo_bridge_if;
   logic        bus_dat_we;
   logic        bus_dat_re;
   logic [31:0] bus_dat_di;
   logic [31:0] bus_dat_do;
   logic        bus_dat_wait;
   logic [31:0] bus_stat_do;
   logic        uart_dat_we;
   logic [31:0] uart_dat_di;
   logic        uart_dat_wait;
   logic        uart_dat_re;
   logic [31:0] uart_dat_do;

   modport slave (
      input  bus_dat_we, bus_dat_re, bus_dat_di, uart_dat_wait, uart_dat_do,
      output bus_dat_do, bus_dat_wait, bus_stat_do, uart_dat_we, uart_dat_di, uart_dat_re
   );

   modport master (
      output bus_dat_we, bus_dat_re, bus_dat_di, uart_dat_wait, uart_dat_do,
      input  bus_dat_do, bus_dat_wait, bus_stat_do, uart_dat_we, uart_dat_di, uart_dat_re
   );
endinterface

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU data register and the UART data register.
// Optional registered irq output when UART_FIFO_IRQ_EN is defined.
module uart_fifo_bridge #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic clk,
   input  logic reset,
   uart_fifo_bridge_if.slave io
`ifdef UART_FIFO_IRQ_EN
   ,
   output logic irq
`endif
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [7:0]            tx_mem_q [DEPTH];
   logic [7:0]            tx_mem_d [DEPTH];
   logic [7:0]            rx_mem_q [DEPTH];
   logic [7:0]            rx_mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [DEPTH_LOG2:0]   tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic unused_bits;

   function automatic logic [DEPTH_LOG2:0] lvl_next(input logic [DEPTH_LOG2:0] lvl,
                                                   input logic up, input logic dn);
      logic [DEPTH_LOG2:0] r;
      r = lvl;
      if (up && !dn)      r = lvl + LVL_ONE;
      else if (!up && dn) r = lvl - LVL_ONE;
      return r;
   endfunction

   assign tx_full  = (tx_lvl_q == FULL_LVL);
   assign tx_empty = (tx_lvl_q == '0);
   assign rx_full  = (rx_lvl_q == FULL_LVL);
   assign rx_empty = (rx_lvl_q == '0);

   // Full flags are registered, so a drain never releases the CPU wait in the same cycle.
   assign tx_push = io.bus_dat_we && !tx_full;
   assign tx_pop  = !tx_empty && !io.uart_dat_wait;
   assign rx_push = io.uart_dat_re;
   assign rx_pop  = io.bus_dat_re && !rx_empty;

   always_comb begin
      tx_mem_d = tx_mem_q;
      rx_mem_d = rx_mem_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_q] = io.bus_dat_di[7:0];
         tx_wr_d           = tx_wr_q + PTR_ONE;
      end
      if (tx_pop) tx_rd_d = tx_rd_q + PTR_ONE;
      if (rx_push) begin
         rx_mem_d[rx_wr_q] = io.uart_dat_do[7:0];
         rx_wr_d           = rx_wr_q + PTR_ONE;
      end
      if (rx_pop) rx_rd_d = rx_rd_q + PTR_ONE;
      tx_lvl_d = lvl_next(tx_lvl_q, tx_push, tx_pop);
      rx_lvl_d = lvl_next(rx_lvl_q, rx_push, rx_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_lvl_q <= '0;
         rx_lvl_q <= '0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         tx_lvl_q <= tx_lvl_d;
         rx_lvl_q <= rx_lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   assign io.uart_dat_we  = !tx_empty;
   assign io.uart_dat_di  = {24'b0, tx_mem_q[tx_rd_q]};
   assign io.uart_dat_re  = io.uart_dat_do[8] && !rx_full && !reset;
   assign io.bus_dat_do   = rx_empty ? 32'b0 : {23'b0, 1'b1, rx_mem_q[rx_rd_q]};
   assign io.bus_dat_wait = io.bus_dat_we && tx_full;
   assign io.bus_stat_do  = {8'b0, 8'(tx_lvl_q), 8'(rx_lvl_q),
                             4'b0, tx_full, tx_empty, rx_full, !rx_empty};

   assign unused_bits = ^{io.bus_dat_di[31:8], io.uart_dat_do[31:9]};

`ifdef UART_FIFO_IRQ_EN
   logic irq_q, irq_d;
   logic rx_ne_prev_q, rx_ne_prev_d, tx_ne_prev_q, tx_ne_prev_d;

   // Edge events: RX goes nonempty, or TX drains to empty; any CPU access acknowledges.
   always_comb begin
      rx_ne_prev_d = !rx_empty;
      tx_ne_prev_d = !tx_empty;
      irq_d        = irq_q;
      if (io.bus_dat_re || io.bus_dat_we)   irq_d = 1'b0;
      else if ((!rx_empty && !rx_ne_prev_q) ||
               (tx_empty && tx_ne_prev_q))  irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q        <= 1'b0;
         rx_ne_prev_q <= 1'b0;
         tx_ne_prev_q <= 1'b0;
      end else begin
         irq_q        <= irq_d;
         rx_ne_prev_q <= rx_ne_prev_d;
         tx_ne_prev_q <= tx_ne_prev_d;
      end
   end

   assign irq = irq_q;
`endif
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with 4-entry FIFOs (DEPTH_LOG2=2).
// The UART busy line is modelled as uart_dat_we gated by a bench stall flag.
module tb_uart_fifo_bridge;
   logic clk = 1'b0;
   logic reset;
   logic uart_stall;
   int   n_cmp = 0;
   int   n_mis = 0;
`ifdef UART_FIFO_IRQ_EN
   logic irq_w;
`endif

   uart_fifo_bridge_if io ();

   assign io.uart_dat_wait = io.uart_dat_we & uart_stall;

   uart_fifo_bridge #(.DEPTH_LOG2(2)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
`ifdef UART_FIFO_IRQ_EN
      ,
      .irq   (irq_w)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] tx_bytes [5];
      logic [7:0] rx_bytes [5];
      tx_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      rx_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

      reset          = 1'b1;
      uart_stall     = 1'b1;
      io.bus_dat_we  = 1'b0;
      io.bus_dat_re  = 1'b0;
      io.bus_dat_di  = 32'h0;
      io.uart_dat_do = 32'h0;
      repeat (3) step();
      reset = 1'b0;
      step();
      #1;
      check("rst_stat", io.bus_stat_do, 32'h0000_0004);
      check("rst_uwe", 32'(io.uart_dat_we), 32'h0);
      check("rst_do", io.bus_dat_do, 32'h0);
      check("rst_wait", 32'(io.bus_dat_wait), 32'h0);
      check("rst_ure", 32'(io.uart_dat_re), 32'h0);

      // TX: three writes with the UART busy, drained in order after release
      io.bus_dat_we = 1'b1;
      io.bus_dat_di = 32'h41;
      #1;
      check("tx_uwe_same_cycle", 32'(io.uart_dat_we), 32'h0);
      step();
      #1;
      check("tx_uwe_lat", 32'(io.uart_dat_we), 32'h1);
      check("tx_head0", io.uart_dat_di, 32'h41);
      io.bus_dat_di = 32'h42;
      step();
      io.bus_dat_di = 32'h43;
      step();
      io.bus_dat_we = 1'b0;
      repeat (20) step();
      check("tx_lvl3", io.bus_stat_do, 32'h0003_0000);
      check("tx_head_held", io.uart_dat_di, 32'h41);
      uart_stall = 1'b0;
      #1;
      check("tx_acc0", io.uart_dat_di, 32'h41);
      step();
      check("tx_acc1", io.uart_dat_di, 32'h42);
      step();
      check("tx_acc2", io.uart_dat_di, 32'h43);
      step();
      check("tx_drained_uwe", 32'(io.uart_dat_we), 32'h0);
      check("tx_drained_stat", io.bus_stat_do, 32'h0000_0004);

      // TX full: fifth write waits until one UART accept frees a slot
      uart_stall    = 1'b1;
      io.bus_dat_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         io.bus_dat_di = 32'(tx_bytes[i]);
         step();
      end
      io.bus_dat_di = 32'(tx_bytes[4]);
      #1;
      check("full_wait", 32'(io.bus_dat_wait), 32'h1);
      check("full_stat", io.bus_stat_do, 32'h0004_0008);
      step();
      check("full_wait_hold", 32'(io.bus_dat_wait), 32'h1);
      uart_stall = 1'b0;
      #1;
      check("full_wait_same_drain", 32'(io.bus_dat_wait), 32'h1);
      step();
      uart_stall = 1'b1;
      #1;
      check("full_wait_released", 32'(io.bus_dat_wait), 32'h0);
      check("full_lvl3", io.bus_stat_do, 32'h0003_0000);
      step();
      io.bus_dat_we = 1'b0;
      #1;
      check("full_again", io.bus_stat_do, 32'h0004_0008);
      uart_stall = 1'b0;
      for (int i = 1; i < 5; i++) begin
         #1;
         check($sformatf("full_drain%0d", i), io.uart_dat_di, 32'(tx_bytes[i]));
         step();
      end
      check("full_empty", io.bus_stat_do, 32'h0000_0004);
      uart_stall = 1'b1;

      // RX: single byte captured, read, popped
      io.uart_dat_do = 32'h155;
      #1;
      check("rx_ure_pulse", 32'(io.uart_dat_re), 32'h1);
      step();
      io.uart_dat_do = 32'h055;
      #1;
      check("rx_ure_low", 32'(io.uart_dat_re), 32'h0);
      check("rx_do", io.bus_dat_do, 32'h0000_0155);
      check("rx_stat", io.bus_stat_do, 32'h0000_0105);
      io.bus_dat_re = 1'b1;
      step();
      io.bus_dat_re = 1'b0;
      #1;
      check("rx_popped", io.bus_dat_do, 32'h0);
      check("rx_popped_stat", io.bus_stat_do, 32'h0000_0004);

      // RX empty read changes nothing; push+pop on empty keeps the byte
      io.bus_dat_re = 1'b1;
      step();
      check("rx_empty_read", io.bus_stat_do, 32'h0000_0004);
      io.uart_dat_do = 32'h1AA;
      #1;
      check("rx_pp_do", io.bus_dat_do, 32'h0);
      step();
      io.bus_dat_re  = 1'b0;
      io.uart_dat_do = 32'h0;
      #1;
      check("rx_pp_kept", io.bus_dat_do, 32'h0000_01AA);
      check("rx_pp_lvl", io.bus_stat_do, 32'h0000_0105);
      io.bus_dat_re = 1'b1;
      step();
      io.bus_dat_re = 1'b0;

      // RX full: fifth byte held in the UART until one CPU read
      for (int i = 0; i < 4; i++) begin
         io.uart_dat_do = {23'b0, 1'b1, rx_bytes[i]};
         step();
      end
      io.uart_dat_do = {23'b0, 1'b1, rx_bytes[4]};
      #1;
      check("rxf_ure_blocked", 32'(io.uart_dat_re), 32'h0);
      check("rxf_stat", io.bus_stat_do, 32'h0000_0407);
      step();
      check("rxf_ure_still", 32'(io.uart_dat_re), 32'h0);
      io.bus_dat_re = 1'b1;
      #1;
      check("rxf_head", io.bus_dat_do, 32'h0000_0110);
      check("rxf_ure_same_pop", 32'(io.uart_dat_re), 32'h0);
      step();
      io.bus_dat_re = 1'b0;
      #1;
      check("rxf_ure_after_pop", 32'(io.uart_dat_re), 32'h1);
      step();
      io.uart_dat_do = 32'h0;
      #1;
      check("rxf_full_again", io.bus_stat_do, 32'h0000_0407);
      for (int i = 1; i < 5; i++) begin
         io.bus_dat_re = 1'b1;
         #1;
         check($sformatf("rxf_read%0d", i), io.bus_dat_do, {23'b0, 1'b1, rx_bytes[i]});
         step();
      end
      io.bus_dat_re = 1'b0;
      #1;
      check("rxf_empty", io.bus_dat_do, 32'h0);

      // Reset with three bytes in each FIFO
      io.bus_dat_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io.bus_dat_di  = 32'h61 + 32'(i);
         io.uart_dat_do = 32'h171 + 32'(i);
         step();
      end
      io.bus_dat_we  = 1'b0;
      io.uart_dat_do = 32'h0;
      #1;
      check("pre_rst_stat", io.bus_stat_do, 32'h0003_0301);
      reset          = 1'b1;
      io.uart_dat_do = 32'h1EE;
      #1;
      check("rst_ure_gated", 32'(io.uart_dat_re), 32'h0);
      step();
      reset          = 1'b0;
      io.uart_dat_do = 32'h0;
      #1;
      check("post_rst_stat", io.bus_stat_do, 32'h0000_0004);
      check("post_rst_uwe", 32'(io.uart_dat_we), 32'h0);
      check("post_rst_do", io.bus_dat_do, 32'h0);
`ifdef UART_FIFO_IRQ_EN
      check("post_rst_irq", 32'(irq_w), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
